// File: rtl/gfx_span_writer.sv
// Span-fill engine: queues horizontal spans, clips each to the framebuffer and
// scissor, and streams ARGB8888 or RGB565 VRAM store beats on a valid/ready port.
module gfx_span_writer #(
    parameter int unsigned QDEPTH    = 4,
    parameter int unsigned COORD_W   = 16,
    parameter int unsigned EN_RGB565 = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [31:0]        fb_base,
    input  logic [COORD_W-1:0] fb_stride,
    input  logic               fb_format,
    input  logic [COORD_W-1:0] fb_w,
    input  logic [COORD_W-1:0] fb_h,
    input  logic               sc_en,
    input  logic [COORD_W-1:0] sc_x0,
    input  logic [COORD_W-1:0] sc_y0,
    input  logic [COORD_W-1:0] sc_w,
    input  logic [COORD_W-1:0] sc_h,
    input  logic               span_valid,
    output logic               span_ready,
    input  logic [COORD_W-1:0] span_x0,
    input  logic [COORD_W-1:0] span_x1,
    input  logic [COORD_W-1:0] span_y,
    input  logic [31:0]        span_color,
    output logic               st_valid,
    input  logic               st_ready,
    output logic [31:0]        st_addr,
    output logic [31:0]        st_wdata,
    output logic [3:0]         st_wstrb,
    output logic               span_done,
    output logic               busy,
    output logic [31:0]        pix_count
);

    localparam int unsigned PTR_W  = $clog2(QDEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned XW     = COORD_W + 1;
    localparam int unsigned PROD_W = 2 * COORD_W;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EMIT} state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y;
        logic [31:0]        color;
    } span_t;

    state_e             state_q, state_d;
    span_t              mem_q [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    span_t              wk_q, wk_d;
    logic [31:0]        row_base_q, row_base_d;
    logic [XW-1:0]      right_q, right_d, cur_x_q, cur_x_d;
    logic               fmt_q, fmt_d;
    logic               st_valid_q, st_valid_d;
    logic [31:0]        st_addr_q, st_addr_d, st_wdata_q, st_wdata_d;
    logic [3:0]         st_wstrb_q, st_wstrb_d;
    logic               span_done_q, span_done_d;
    logic [31:0]        pix_count_q, pix_count_d;
    logic               busy_q, busy_d;
    logic               span_ready_q, span_ready_d;
    logic               push, pop;

    span_t              span_in_c;
    logic               fmt_c, reject_c;
    logic [XW-1:0]      sc_l_c, sc_r_c, sc_b_c, fb_r_c, left_c, right_c;
    logic [PROD_W-1:0]  prod_c;
    logic [31:0]        row_base_c, wdata_c;
    logic [15:0]        p565_c;
    logic [XW-1:0]      adv_c, next_x_c;

    function automatic logic [31:0] beat_addr(input logic [31:0] rb, input logic fmt,
                                              input logic [XW-1:0] x);
        logic [31:0] off;
        off = fmt ? ((32'(x) << 1) & ~32'd3) : (32'(x) << 2);
        return rb + off;
    endfunction

    function automatic logic [3:0] beat_strb(input logic fmt, input logic [XW-1:0] x,
                                             input logic [XW-1:0] r);
        if (!fmt)   return 4'hF;
        if (x[0])   return 4'hC;
        if (x < r)  return 4'hF;
        return 4'h3;
    endfunction

    assign span_in_c = '{x0: span_x0, x1: span_x1, y: span_y, color: span_color};

    // Clip window, computed one bit wider so scissor sums never wrap
    assign fmt_c  = (EN_RGB565 != 0) && fb_format;
    assign sc_l_c = sc_en ? XW'(sc_x0) : '0;
    assign sc_r_c = XW'(sc_x0) + XW'(sc_w) - XW'(1);
    assign sc_b_c = XW'(sc_y0) + XW'(sc_h);
    assign fb_r_c = XW'(fb_w) - XW'(1);
    assign left_c = (XW'(wk_q.x0) > sc_l_c) ? XW'(wk_q.x0) : sc_l_c;

    always_comb begin
        right_c = XW'(wk_q.x1);
        if (fb_r_c < right_c)          right_c = fb_r_c;
        if (sc_en && sc_r_c < right_c) right_c = sc_r_c;
    end

    assign reject_c = (fb_w == '0) || (fb_h == '0) || (wk_q.y >= fb_h)
                   || (sc_en && ((wk_q.y < sc_y0) || (XW'(wk_q.y) >= sc_b_c)
                                 || (sc_w == '0) || (sc_h == '0)))
                   || (wk_q.x0 > wk_q.x1) || (left_c > right_c);

    assign prod_c     = PROD_W'(wk_q.y) * PROD_W'(fb_stride);
    assign row_base_c = fb_base + 32'(prod_c);
    assign p565_c     = {wk_q.color[23:19], wk_q.color[15:10], wk_q.color[7:3]};
    assign wdata_c    = fmt_c ? {p565_c, p565_c} : wk_q.color;

    // An even RGB565 pixel with a right neighbour in range shares its word
    assign adv_c    = (fmt_q && !cur_x_q[0] && (cur_x_q < right_q)) ? XW'(2) : XW'(1);
    assign next_x_c = cur_x_q + adv_c;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        wk_d         = wk_q;
        row_base_d   = row_base_q;
        right_d      = right_q;
        fmt_d        = fmt_q;
        cur_x_d      = cur_x_q;
        st_valid_d   = st_valid_q;
        st_addr_d    = st_addr_q;
        st_wdata_d   = st_wdata_q;
        st_wstrb_d   = st_wstrb_q;
        span_done_d  = 1'b0;
        pix_count_d  = pix_count_q;
        push         = span_valid && span_ready_q && !flush;
        pop          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    wk_d    = mem_q[rd_ptr_q];
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                row_base_d = row_base_c;
                right_d    = right_c;
                fmt_d      = fmt_c;
                if (reject_c) begin
                    span_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cur_x_d    = left_c;
                    st_valid_d = 1'b1;
                    st_addr_d  = beat_addr(row_base_c, fmt_c, left_c);
                    st_wdata_d = wdata_c;
                    st_wstrb_d = beat_strb(fmt_c, left_c, right_c);
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                if (st_ready) begin
                    pix_count_d = pix_count_q + 32'(adv_c);
                    if (next_x_c > right_q) begin
                        st_valid_d  = 1'b0;
                        span_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        cur_x_d    = next_x_c;
                        st_addr_d  = beat_addr(row_base_q, fmt_q, next_x_c);
                        st_wstrb_d = beat_strb(fmt_q, next_x_c, right_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

        // Flush drops everything queued or in flight but keeps the pixel tally
        if (flush) begin
            state_d     = S_IDLE;
            st_valid_d  = 1'b0;
            span_done_d = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
        end

        span_ready_d = (cnt_d != CNT_W'(QDEPTH));
        busy_d       = (cnt_d != '0) || (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            wk_q         <= '0;
            row_base_q   <= '0;
            right_q      <= '0;
            fmt_q        <= 1'b0;
            cur_x_q      <= '0;
            st_valid_q   <= 1'b0;
            st_addr_q    <= '0;
            st_wdata_q   <= '0;
            st_wstrb_q   <= '0;
            span_done_q  <= 1'b0;
            pix_count_q  <= '0;
            busy_q       <= 1'b0;
            span_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            wk_q         <= wk_d;
            row_base_q   <= row_base_d;
            right_q      <= right_d;
            fmt_q        <= fmt_d;
            cur_x_q      <= cur_x_d;
            st_valid_q   <= st_valid_d;
            st_addr_q    <= st_addr_d;
            st_wdata_q   <= st_wdata_d;
            st_wstrb_q   <= st_wstrb_d;
            span_done_q  <= span_done_d;
            pix_count_q  <= pix_count_d;
            busy_q       <= busy_d;
            span_ready_q <= span_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= span_in_c;
    end

    assign span_ready = span_ready_q;
    assign st_valid   = st_valid_q;
    assign st_addr    = st_addr_q;
    assign st_wdata   = st_wdata_q;
    assign st_wstrb   = st_wstrb_q;
    assign span_done  = span_done_q;
    assign busy       = busy_q;
    assign pix_count  = pix_count_q;

endmodule

// File: doc/gfx_span_writer.md
Name: gfx_span_writer

Overview:
- Parametrised framebuffer span-fill engine for the graphics pipeline, and the successor to the fixed ARGB8888 single-pixel GDRAW store path.
- Accepts horizontal span commands (x0..x1 on row y, flat colour) into a FIFO and clips each span to the framebuffer and optional scissor.
- Emits 32-bit VRAM store beats on a valid/ready store port.
- Supports ARGB8888 (one pixel per beat) and RGB565 (two pixels per beat, byte-strobed), with a configurable FIFO depth.

Parameters:
- QDEPTH, 4, span command FIFO depth (power of 2, >=2)
- COORD_W, 16, width of x/y/w/h/stride fields
- EN_RGB565, 1, 0 = fb_format forced to ARGB8888

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous discard of queued and in-flight spans
- fb_base  in  32  framebuffer byte base
- fb_stride  in  COORD_W  row pitch in bytes
- fb_format  in  1  0 = ARGB8888, 1 = RGB565
- fb_w, fb_h  in  COORD_W  framebuffer size in pixels
- sc_en  in  1  scissor enable
- sc_x0, sc_y0, sc_w, sc_h  in  COORD_W  scissor rectangle
- span_valid  in  1  span command valid
- span_ready  out  1  FIFO not full
- span_x0, span_x1  in  COORD_W  inclusive x range (unsigned)
- span_y  in  COORD_W  row
- span_color  in  32  ARGB8888 colour
- st_valid  out  1  store beat valid
- st_ready  in  1  store accepted
- st_addr  out  32  word-aligned byte address
- st_wdata  out  32  store data
- st_wstrb  out  4  byte strobes
- span_done  out  1  one-cycle pulse per retired span
- busy  out  1  FIFO non-empty or FSM not IDLE
- pix_count  out  32  pixels written, wraps mod 2^32

Behaviour:
- Reset (rst high, async):
  - st_valid, st_addr, st_wdata, st_wstrb, span_done, pix_count = 0.
  - FIFO empty, so span_ready = 1 and busy = 0.
  - FSM = IDLE.
- Push handshake:
  - A span is pushed on span_valid & span_ready.
  - span_ready = !full; it does not depend on a same-cycle pop.
- FSM IDLE:
  - If the FIFO is non-empty, pop the head into working registers and go to SETUP.
- FSM SETUP (1 cycle):
  - Latch all fb_* and sc_* inputs; these are held for the whole span.
  - left = max(x0, sc_en ? sc_x0 : 0).
  - right = min(x1, fb_w-1, sc_en ? sc_x0+sc_w-1 : max).
  - All scissor sums are computed at COORD_W+1 bits, with no wrap.
  - Reject the span if any of the following holds: fb_w==0; fb_h==0; y>=fb_h; sc_en and (y<sc_y0 or y>=sc_y0+sc_h or sc_w==0 or sc_h==0); x0>x1; left>right.
  - On reject: pulse span_done, return to IDLE, issue no stores.
  - Otherwise: cur_x = left, go to EMIT.
- Latency:
  - For a span pushed at edge E into an idle, empty block, st_valid is high from edge E+2.
  - Successive spans each incur IDLE + SETUP (2 cycles) after the previous span_done.
- FSM EMIT, ARGB8888:
  - st_addr = fb_base + y*fb_stride + cur_x*4.
  - st_wdata = span_color, st_wstrb = 4'hF.
  - On acceptance, cur_x += 1.
- FSM EMIT, RGB565:
  - Pixel p = {c[23:19], c[15:10], c[7:3]}; st_wdata = {p,p} always.
  - st_addr = fb_base + y*fb_stride + ((cur_x*2) & ~3).
  - cur_x odd: wstrb = 4'hC, advance 1.
  - cur_x even and cur_x < right: wstrb = 4'hF, advance 2.
  - cur_x even and cur_x == right: wstrb = 4'h3, advance 1.
- Address arithmetic:
  - y*fb_stride is an unsigned 2*COORD_W-bit product.
  - Address sums are taken modulo 2^32.
- Store handshake:
  - While st_valid & !st_ready, st_addr, st_wdata and st_wstrb are held stable.
  - No beat is dropped or duplicated.
  - On each accepted beat, pix_count += pixels in that beat (1, or 1/2 for 565).
- Span retirement:
  - Once the beat covering right is accepted: pulse span_done in the next cycle, st_valid falls, FSM goes to IDLE.
- Ordering:
  - Spans are retired strictly in push order.
- flush:
  - Empties the FIFO, deasserts st_valid next cycle and sets FSM to IDLE.
  - No span_done is generated; pix_count is retained.
  - flush wins over a same-cycle push, and that push is discarded.
- rst mid-span:
  - Immediate return to reset state; no further beats are issued.

Test Plan:
- ARGB8888 fill: fb_base=0x2000, stride=32, w=h=8, span x0=1 x1=6 y=1 colour 0x55AA1234 -> 6 beats at addr 0x2024..0x2038 step 4, data 0x55AA1234, strb F; one span_done; pix_count=6.
- RGB565 fill: stride=16, span x0=1 x1=4 y=2 colour 0x00FF8040 (p=0xFC08) -> beats (0x2020, C), (0x2024, F), (0x2028, 3), all with data 0xFC08FC08; pix_count=4.
- Clipping:
  - sc_en with x0=2 w=3 y0=0 h=8, span 0..7 y=3 ARGB -> x=2,3,4 only (addr 0x2068, 0x206C, 0x2070).
  - sc_en=0, span 5..20 -> x=5..7 only.
- Rejects: y=8 with h=8; x0=5 x1=3; fb_w=0 -> zero beats, one span_done each, pix_count unchanged, busy falls.
- Backpressure/FIFO: hold st_ready=0 while pushing 5 spans with QDEPTH=4 -> span_ready low after the FIFO is full; outputs stable during the stall. Then toggle st_ready 1/0 -> all spans complete in order with no duplicate or missing addresses.
- flush/reset mid-span:
  - flush during beat 3 of a 6-pixel span with 2 queued -> st_valid low next cycle, no span_done, busy=0, pix_count=2.
  - Async rst mid-span -> all outputs 0 immediately, span_ready=1.
